// File: rtl/rx192_train_detect.sv
// rx192_train_detect: locks onto the ESC -> IDLE -> SYNC training sequence of a
// 192-bit word stream, then forwards payload words over a valid/ready handshake.
module rx192_train_detect #(
  parameter logic [47:0] ESC_WORD  = 48'hFBFB_FBFB_FBFB,
  parameter logic [47:0] IDLE_WORD = 48'h0707_0707_0707,
  parameter logic [47:0] SYNC_WORD = 48'hA5A5_A5A5_A000,
  parameter int unsigned ESC_CNT   = 4,
  parameter int unsigned IDLE_CNT  = 4,
  parameter int unsigned SYNC_CNT  = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [191:0] in_data,
  input  logic         in_txen,
  output logic         ideal,
  output logic [191:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         link_up,
  output logic [2:0]   state,
  output logic [7:0]   err_cnt
);
  typedef enum logic [2:0] {HUNT = 3'd0, ESC = 3'd1, IDLE = 3'd2, SYNC = 3'd3, LINK = 3'd4} state_t;

  state_t         r_state, w_nstate;
  logic [7:0]     r_cnt, w_ncnt, r_err;
  logic           r_link, r_valid;
  logic [191:0]   r_data;
  logic           w_acc, w_esc, w_idle, w_sync, w_err, w_fwd;
  logic [7:0]     w_cnt_inc, w_err_inc;

  // a word is a training word only when all four chars carry the pattern
  assign w_esc     = in_data == {4{ESC_WORD}};
  assign w_idle    = in_data == {4{IDLE_WORD}};
  assign w_sync    = in_data == {4{SYNC_WORD}};
  assign ideal     = !r_link | !r_valid | out_ready;
  assign w_acc     = in_txen & ideal;
  assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
  assign w_err_inc = (r_err == 8'hFF) ? r_err : r_err + 8'd1;

  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    w_err    = 1'b0;
    w_fwd    = 1'b0;
    if (w_acc) begin
      case (r_state)
        HUNT: if (w_esc) begin w_nstate = ESC; w_ncnt = 8'd1; end
        ESC:
          if (w_esc) w_ncnt = w_cnt_inc;
          else if (w_idle && r_cnt >= 8'(ESC_CNT)) begin w_nstate = IDLE; w_ncnt = 8'd1; end
          else begin w_nstate = HUNT; w_ncnt = 8'd0; w_err = 1'b1; end
        IDLE:
          if (w_idle) w_ncnt = w_cnt_inc;
          else if (w_sync && r_cnt >= 8'(IDLE_CNT)) begin
            w_nstate = (SYNC_CNT == 1) ? LINK : SYNC;
            w_ncnt   = 8'd1;
          end
          else if (w_esc) begin w_nstate = ESC; w_ncnt = 8'd1; w_err = 1'b1; end
          else begin w_nstate = HUNT; w_ncnt = 8'd0; w_err = 1'b1; end
        SYNC:
          if (w_sync && ({1'b0, r_cnt} + 9'd1) == 9'(SYNC_CNT)) w_nstate = LINK;
          else if (w_sync) w_ncnt = w_cnt_inc;
          else if (w_esc) begin w_nstate = ESC; w_ncnt = 8'd1; w_err = 1'b1; end
          else begin w_nstate = HUNT; w_ncnt = 8'd0; w_err = 1'b1; end
        LINK:
          if (w_esc) begin w_nstate = ESC; w_ncnt = 8'd1; end
          else w_fwd = 1'b1;
        default: begin w_nstate = HUNT; w_ncnt = 8'd0; end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= HUNT;
      r_cnt   <= 8'd0;
      r_err   <= 8'd0;
      r_link  <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      r_link  <= w_nstate == LINK;
      if (w_err) r_err <= w_err_inc;
      if (w_fwd) r_data <= in_data;
      r_valid <= w_fwd | (r_valid & !out_ready);
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign link_up   = r_link;
  assign state     = r_state;
  assign err_cnt   = r_err;
endmodule

// File: tb/tb_rx192_train_detect.sv
// tb_rx192_train_detect: directed and randomized training/payload traffic checked
// against a phase/run-length reference model, with a queue scoreboard on out_data.
module tb_rx192_train_detect;
  localparam logic [47:0] EW = 48'hFBFB_FBFB_FBFB;
  localparam logic [47:0] IW = 48'h0707_0707_0707;
  localparam logic [47:0] SW = 48'hA5A5_A5A5_A000;
  localparam int REQ [3] = '{4, 4, 4};

  logic         clk = 1'b0, reset_n = 1'b0, in_txen = 1'b0, out_ready = 1'b1;
  logic [191:0] in_data = '0;
  logic         ideal, out_valid, link_up;
  logic [191:0] out_data;
  logic [2:0]   state;
  logic [7:0]   err_cnt;

  rx192_train_detect dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_txen(in_txen), .ideal(ideal),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .link_up(link_up), .state(state), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  logic [191:0] q[$];
  int ph = 0, run = 0, merr = 0;
  bit mvalid = 1'b0;
  logic [191:0] e_word, i_word, s_word;

  function automatic void chk(string n, logic [191:0] act, logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endfunction

  // 0=ESC 1=IDLE 2=SYNC 3=other; phase p>=1 expects class p-1, hands over to class p
  function automatic int cls(logic [191:0] d);
    for (int c = 0; c < 3; c++) begin
      logic [47:0] pat;
      bit all_eq;
      pat = (c == 0) ? EW : (c == 1) ? IW : SW;
      all_eq = 1'b1;
      for (int k = 0; k < 4; k++) if (d[k*48 +: 48] != pat) all_eq = 1'b0;
      if (all_eq) return c;
    end
    return 3;
  endfunction

  function automatic void model(logic [191:0] d, bit acc, bit rdy);
    int c;
    bit fwd;
    fwd = 1'b0;
    if (acc) begin
      c = cls(d);
      if (ph == 4) begin
        if (c == 0) begin ph = 1; run = 1; end else fwd = 1'b1;
      end else if (ph == 0) begin
        if (c == 0) begin ph = 1; run = 1; end
      end else if (c == ph - 1) begin
        run = (run < 255) ? run + 1 : 255;
        if (ph == 3 && run == REQ[2]) ph = 4;
      end else if (c == ph && ph < 3 && run >= REQ[ph-1]) begin
        ph++; run = 1;
        if (ph == 3 && run >= REQ[2]) ph = 4;
      end else begin
        merr = (merr < 255) ? merr + 1 : 255;
        if (c == 0) begin ph = 1; run = 1; end else begin ph = 0; run = 0; end
      end
    end
    if (fwd) begin mvalid = 1'b1; q.push_back(d); end
    else if (rdy) mvalid = 1'b0;
  endfunction

  // entered and left at posedge+1
  task automatic step(input logic [191:0] d, input bit t, input bit r);
    bit m_ideal;
    in_data = d; in_txen = t; out_ready = r;
    @(negedge clk);
    m_ideal = (ph != 4) || !mvalid || r;
    chk("ideal", ideal, m_ideal);
    @(posedge clk);
    model(d, t & m_ideal, r);
    #1;
    chk("state", state, ph);
    chk("link_up", link_up, ph == 4);
    chk("err_cnt", err_cnt, merr);
    chk("out_valid", out_valid, mvalid);
  endtask

  task automatic do_reset(input logic [191:0] d, input bit t);
    reset_n = 1'b0; in_data = d; in_txen = t; out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_link", link_up, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_err", err_cnt, 0);
    ph = 0; run = 0; merr = 0; mvalid = 1'b0; q.delete();
    reset_n = 1'b1;
  endtask

  task automatic burst(input logic [191:0] w, input int n);
    repeat (n) step(w, 1'b1, 1'b1);
  endtask

  task automatic train(input int ne, input int ni, input int ns);
    burst(e_word, ne); burst(i_word, ni); burst(s_word, ns);
  endtask

  function automatic logic [191:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL out_data: got unexpected word %0h with no word expected", out_data);
      end else chk("out_data", out_data, q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    e_word = {4{EW}}; i_word = {4{IW}}; s_word = {4{SW}};
    do_reset(e_word, 1'b1);
    train(4, 4, 4);
    chk("t1_linked", link_up, 1'b1);
    step(192'h1, 1'b1, 1'b1);
    step(192'h2, 1'b1, 1'b1);
    step(192'h3, 1'b1, 1'b0);
    chk("t2_hold", out_data, 192'h2);
    step(192'h3, 1'b1, 1'b0);
    step(192'h3, 1'b1, 1'b1);
    step('0, 1'b0, 1'b1);
    do_reset('0, 1'b0);
    train(4, 2, 1);
    train(4, 4, 4);
    do_reset('0, 1'b0);
    train(6, 4, 4);
    do_reset('0, 1'b0);
    train(4, 3, 0);
    burst(e_word, 1);
    train(3, 4, 4);
    step(192'hABC, 1'b1, 1'b1);
    burst(e_word, 1);
    train(3, 4, 4);
    step(192'h55, 1'b1, 1'b1);
    step(192'h66, 1'b1, 1'b0);
    step(192'h66, 1'b1, 1'b0);
    do_reset(192'h66, 1'b1);
    train(4, 4, 2);
    step(s_word, 1'b0, 1'b1);
    step(s_word, 1'b0, 1'b0);
    step(s_word, 1'b1, 1'b0);
    do_reset(s_word, 1'b1);
    repeat (300) begin
      int kind, len;
      logic [191:0] w;
      kind = $urandom_range(0, 6);
      len = $urandom_range(1, 6);
      if (kind == 6 && $urandom_range(0, 9) == 0) do_reset(rnd_word(), 1'b1);
      else if (kind == 5) begin
        burst(e_word, $urandom_range(3, 6)); burst(i_word, $urandom_range(3, 6));
        burst(s_word, $urandom_range(3, 5));
      end else repeat (len) begin
        w = (kind == 0) ? e_word : (kind == 1) ? i_word : (kind == 2) ? s_word : rnd_word();
        step(w, $urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0);
      end
    end
    repeat (3) step('0, 1'b0, 1'b1);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
